// File: rtl/uart_tx_ctrl.sv
`timescale 1ns/1ps
// uart_tx_ctrl
// UART transmit sequencer. A one-entry holding register takes bytes over a
// valid/ready handshake. Each byte is framed as start, data[0..7], stop and
// shifted out LSB first. The bit period is baud_div+1 clk cycles, and
// baud_div is latched when a frame is loaded.
//
// State table:
//   state | meaning
//   IDLE  | line idle (tx=1); waiting for hold_full && en
//   SEND  | frame shifting out; the next frame may chain in with no gap
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   async active-low reset
//   rst       in   sync soft clear, active-high
//   en        in   gates the start of new frames only
//   baud_div  in   [DIV_W-1:0] bit period minus one
//   tx_data   in   [7:0] byte to send
//   tx_valid  in   tx_data valid
//   tx_ready  out  holding register empty (registered)
//   tx        out  serial line, idle high
//   busy      out  high while in SEND
//   tx_done   out  one-cycle pulse after the stop bit completes
module uart_tx_ctrl #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rst,
   input  logic             en,
   input  logic [DIV_W-1:0] baud_div,
   input  logic [7:0]       tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic             tx,
   output logic             busy,
   output logic             tx_done
);

   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

   state_t           state, state_nxt;
   logic [9:0]       frame;
   logic [7:0]       hold;
   logic             hold_full;
   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] cnt;
   logic [3:0]       bit_cnt;
   logic             done_q;

   logic bit_end;
   logic last_bit;
   logic load;
   logic write;

   assign write    = tx_valid && !hold_full;
   assign bit_end  = (state == SEND) && (cnt == div_q);
   assign last_bit = bit_end && (bit_cnt == 4'd9);
   // A new frame loads from IDLE, or back-to-back at the stop-bit end.
   assign load     = hold_full && en && ((state == IDLE) || last_bit);

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (load) state_nxt = SEND;
         SEND: if (last_bit && !load) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // outputs
   always_comb begin
      tx       = frame[0];
      busy     = (state == SEND);
      tx_ready = !hold_full;
      tx_done  = done_q;
   end

   // datapath: holding register, frame shifter, baud and bit counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame     <= 10'h3FF;
         hold      <= 8'h00;
         hold_full <= 1'b0;
         div_q     <= '0;
         cnt       <= '0;
         bit_cnt   <= 4'd0;
         done_q    <= 1'b0;
      end else if (rst) begin
         frame     <= 10'h3FF;
         hold      <= 8'h00;
         hold_full <= 1'b0;
         div_q     <= '0;
         cnt       <= '0;
         bit_cnt   <= 4'd0;
         done_q    <= 1'b0;
      end else begin
         if (write)
            hold <= tx_data;
         // a write coinciding with a drain leaves the register full
         if (write)
            hold_full <= 1'b1;
         else if (load)
            hold_full <= 1'b0;

         done_q <= last_bit;

         if (load) begin
            frame   <= {1'b1, hold, 1'b0};
            div_q   <= baud_div;
            cnt     <= '0;
            bit_cnt <= 4'd0;
         end else if (last_bit) begin
            frame   <= 10'h3FF;
            cnt     <= '0;
            bit_cnt <= 4'd0;
         end else if (bit_end) begin
            frame   <= {1'b1, frame[9:1]};
            cnt     <= '0;
            bit_cnt <= bit_cnt + 4'd1;
         end else if (state == SEND) begin
            cnt <= cnt + DIV_W'(1);
         end
      end
   end

endmodule
